// File: rtl/lsu_pkg.sv
// Shared constants and types for the load/store unit.
// Optional feature macro: LSU_ACCESS_FAULT_EN (see load_store_unit.sv).
package lsu_pkg;

    // Default data-memory depth, log2 of 32-bit words.
    localparam int MEM_DEPTH_LOG2_DEFAULT = 8;

    // RV32I load/store funct3 encodings.
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Response exception codes.
    localparam logic [1:0] EXC_NONE     = 2'b00;
    localparam logic [1:0] EXC_MISALIGN = 2'b01;
    localparam logic [1:0] EXC_ILLEGAL  = 2'b10;
    localparam logic [1:0] EXC_FAULT    = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_RDW  = 3'd2,
        ST_WR   = 3'd3,
        ST_RESP = 3'd4
    } lsu_state_e;

    // True when funct3 is not a legal load (is_store=0) or store (is_store=1).
    function automatic logic is_illegal_f3(input logic is_store, input logic [2:0] f3);
        if (is_store) begin
            return (f3 > F3_W);
        end
        return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

    // True when the access size does not match the low address bits.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b01:   return a[0];
            2'b10:   return (a != 2'b00);
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Request / memory / response bundle of the load/store unit.
// Handshake: a request transfers on a rising clock edge where req_valid_i and
// req_ready_o are both high; upstream holds all req_* fields stable while
// req_valid_i is high and req_ready_o is low. resp_valid_o is a single-cycle
// pulse with no backpressure. mem_re_o data returns on mem_rdata_i one cycle
// later; mem_we_o writes mem_wdata_o at mem_addr_o on the edge it is high.
interface lsu_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_is_store_i;
    logic [2:0]  req_funct3_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic [4:0]  req_rd_i;

    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_we_o;
    logic        mem_re_o;
    logic [31:0] mem_rdata_i;

    logic        resp_valid_o;
    logic        resp_we_o;
    logic [4:0]  resp_rd_o;
    logic [31:0] resp_data_o;
    logic [1:0]  resp_exc_o;

    // The LSU side.
    modport slave (
        input  req_valid_i, req_is_store_i, req_funct3_i, req_addr_i, req_wdata_i, req_rd_i,
        input  mem_rdata_i,
        output req_ready_o,
        output mem_addr_o, mem_wdata_o, mem_we_o, mem_re_o,
        output resp_valid_o, resp_we_o, resp_rd_o, resp_data_o, resp_exc_o
    );

    // The pipeline / memory side.
    modport master (
        output req_valid_i, req_is_store_i, req_funct3_i, req_addr_i, req_wdata_i, req_rd_i,
        output mem_rdata_i,
        input  req_ready_o,
        input  mem_addr_o, mem_wdata_o, mem_we_o, mem_re_o,
        input  resp_valid_o, resp_we_o, resp_rd_o, resp_data_o, resp_exc_o
    );
endinterface

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: load extraction and sub-word store merge.
import lsu_pkg::*;

module lsu_align (
    input  logic [31:0] ld_rdata_i,
    input  logic [31:0] st_old_i,
    input  logic [31:0] st_wdata_i,
    input  logic [1:0]  addr_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] ld_data_o,
    output logic [31:0] st_word_o
);

    // Select the addressed byte/halfword and sign- or zero-extend it.
    function automatic logic [31:0] load_extract(input logic [31:0] rdata,
                                                 input logic [1:0]  a,
                                                 input logic [2:0]  f3);
        logic [7:0]  b;
        logic [15:0] h;
        b = rdata[8*a +: 8];
        h = a[1] ? rdata[31:16] : rdata[15:0];
        case (f3)
            F3_B:    return {{24{b[7]}}, b};
            F3_BU:   return {24'h0, b};
            F3_H:    return {{16{h[15]}}, h};
            F3_HU:   return {16'h0, h};
            default: return rdata;
        endcase
    endfunction

    // Replace only the addressed byte/halfword of the old word.
    function automatic logic [31:0] store_merge(input logic [31:0] old,
                                                input logic [31:0] wdata,
                                                input logic [1:0]  a,
                                                input logic [2:0]  f3);
        logic [31:0] w;
        w = old;
        case (f3)
            F3_B: w[8*a +: 8] = wdata[7:0];
            F3_H: begin
                if (a[1]) w[31:16] = wdata[15:0];
                else      w[15:0]  = wdata[15:0];
            end
            default: w = wdata;
        endcase
        return w;
    endfunction

    assign ld_data_o = load_extract(ld_rdata_i, addr_i, funct3_i);
    assign st_word_o = store_merge(st_old_i, st_wdata_i, addr_i, funct3_i);

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit for a word-addressed data memory without byte
// enables. Sub-word stores are done as read-modify-write.
// Optional feature: define LSU_ACCESS_FAULT_EN to report addresses beyond the
// memory as access faults; otherwise upper address bits wrap.
import lsu_pkg::*;

module load_store_unit #(
    parameter int MEM_DEPTH_LOG2 = MEM_DEPTH_LOG2_DEFAULT
) (
    input  logic       clk_i,
    input  logic       reset_i,
    lsu_if.slave       bus,
    output logic [2:0] dbg_state_o
);

    localparam logic [2:0] S_IDLE = ST_IDLE;
    localparam logic [2:0] S_RD   = ST_RD;
    localparam logic [2:0] S_RDW  = ST_RDW;
    localparam logic [2:0] S_WR   = ST_WR;
    localparam logic [2:0] S_RESP = ST_RESP;

    localparam int AW = MEM_DEPTH_LOG2 + 2;

    logic [2:0]    state_q, state_d;
    logic [AW-1:0] addr_q;
    logic [2:0]    f3_q;
    logic          store_q;
    logic [4:0]    rd_q;
    logic [31:0]   wdata_q;
    logic [31:0]   data_q;
    logic [1:0]    exc_q;

    logic          accept;
    logic          fault_in;
    logic [1:0]    exc_in;
    logic [31:0]   ld_data;
    logic [31:0]   st_word;

    assign accept = bus.req_valid_i && (state_q == S_IDLE);

`ifdef LSU_ACCESS_FAULT_EN
    assign fault_in = |bus.req_addr_i[31:AW];
`else
    logic unused_addr_hi;
    assign fault_in       = 1'b0;
    assign unused_addr_hi = ^bus.req_addr_i[31:AW];
`endif

    // Exception decode of the incoming request, illegal > misaligned > fault.
    always_comb begin
        exc_in = EXC_NONE;
        if (is_illegal_f3(bus.req_is_store_i, bus.req_funct3_i)) begin
            exc_in = EXC_ILLEGAL;
        end else if (is_misaligned(bus.req_funct3_i, bus.req_addr_i[1:0])) begin
            exc_in = EXC_MISALIGN;
        end else if (fault_in) begin
            exc_in = EXC_FAULT;
        end
    end

    lsu_align u_align (
        .ld_rdata_i (bus.mem_rdata_i),
        .st_old_i   (bus.mem_rdata_i),
        .st_wdata_i (wdata_q),
        .addr_i     (addr_q[1:0]),
        .funct3_i   (f3_q),
        .ld_data_o  (ld_data),
        .st_word_o  (st_word)
    );

    // Next-state selection for the access sequence.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (exc_in != EXC_NONE)                               state_d = S_RESP;
                    else if (bus.req_is_store_i && bus.req_funct3_i == F3_W) state_d = S_WR;
                    else                                                  state_d = S_RD;
                end
            end
            S_RD:    state_d = S_RDW;
            S_RDW:   state_d = store_q ? S_WR : S_RESP;
            S_WR:    state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Request capture, then load result or merged store word in RDW.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            addr_q  <= '0;
            f3_q    <= '0;
            store_q <= 1'b0;
            rd_q    <= '0;
            wdata_q <= '0;
            data_q  <= '0;
            exc_q   <= EXC_NONE;
        end else if (accept) begin
            addr_q  <= bus.req_addr_i[AW-1:0];
            f3_q    <= bus.req_funct3_i;
            store_q <= bus.req_is_store_i;
            rd_q    <= bus.req_rd_i;
            wdata_q <= bus.req_wdata_i;
            data_q  <= '0;
            exc_q   <= exc_in;
        end else if (state_q == S_RDW) begin
            if (store_q) wdata_q <= st_word;
            else         data_q  <= ld_data;
        end
    end

    assign bus.req_ready_o  = (state_q == S_IDLE);
    assign bus.mem_re_o     = (state_q == S_RD);
    assign bus.mem_we_o     = (state_q == S_WR);
    assign bus.mem_addr_o   = 32'(addr_q[AW-1:2]);
    assign bus.mem_wdata_o  = wdata_q;
    assign bus.resp_valid_o = (state_q == S_RESP);
    assign bus.resp_we_o    = (state_q == S_RESP) && !store_q && (exc_q == EXC_NONE);
    assign bus.resp_rd_o    = rd_q;
    assign bus.resp_data_o  = data_q;
    assign bus.resp_exc_o   = exc_q;
    assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a 256-word memory model and a
// reference model that predicts each response when the request is driven.
module tb_load_store_unit;

    localparam int W = 48;  // {lat[7:0], rd[4:0], we, exc[1:0], data[31:0]}

    logic       clk;
    logic       rst_n;
    logic [2:0] dbg_state;

    lsu_if bus ();

    load_store_unit dut (
        .clk_i       (clk),
        .reset_i     (rst_n),
        .bus         (bus.slave),
        .dbg_state_o (dbg_state)
    );

    logic [31:0]  mem     [256];
    logic [31:0]  ref_mem [256];
    logic [W-1:0] exp_q   [$];
    int           acc_q   [$];
    int           cyc = 0;
    int           we_cnt = 0;
    int           re_cnt = 0;
    int           n_checks = 0;
    int           n_pass = 0;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- memory model ----------------
    always @(posedge clk) begin
        if (bus.mem_we_o) begin
            mem[bus.mem_addr_o[7:0]] <= bus.mem_wdata_o;
            we_cnt <= we_cnt + 1;
        end
        if (bus.mem_re_o) begin
            bus.mem_rdata_i <= mem[bus.mem_addr_o[7:0]];
            re_cnt <= re_cnt + 1;
        end
    end

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        else             n_pass++;
    endtask

    // ---------------- reference model ----------------
    function automatic logic [1:0] ref_exc(input logic st, input logic [2:0] f3, input logic [31:0] a);
        logic ill;
        ill = st ? (f3 inside {3'b011, 3'b100, 3'b101, 3'b110, 3'b111})
                 : (f3 inside {3'b011, 3'b110, 3'b111});
        if (ill) return 2'b10;
        if ((f3 == 3'b001 || f3 == 3'b101) && a[0]) return 2'b01;
        if (f3 == 3'b010 && a[1:0] != 2'b00) return 2'b01;
`ifdef LSU_ACCESS_FAULT_EN
        if (a[31:10] != 22'h0) return 2'b11;
`endif
        return 2'b00;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] a, input logic [2:0] f3);
        logic [31:0] sb, sh;
        sb = w >> (8 * a);
        sh = w >> (16 * a[1]);
        case (f3)
            3'b000:  return {{24{sb[7]}}, sb[7:0]};
            3'b100:  return {24'h0, sb[7:0]};
            3'b001:  return {{16{sh[15]}}, sh[15:0]};
            3'b101:  return {16'h0, sh[15:0]};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [1:0] a, input logic [2:0] f3);
        logic [31:0] mask;
        case (f3)
            3'b000:  mask = 32'h0000_00FF << (8 * a);
            3'b001:  mask = 32'h0000_FFFF << (16 * a[1]);
            default: mask = 32'hFFFF_FFFF;
        endcase
        return (old & ~mask) | ((wd << (8 * a)) & mask);
    endfunction

    // ---------------- driver ----------------
    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [4:0] rd, input bit hold);
        logic [1:0]  exc;
        logic [7:0]  idx;
        logic [31:0] data;
        logic        we;
        logic [7:0]  lat;
        int          w;
        exc  = ref_exc(st, f3, a);
        idx  = a[9:2];
        data = 32'h0;
        we   = 1'b0;
        if (exc != 2'b00) begin
            lat = 8'd1;
        end else if (st) begin
            ref_mem[idx] = ref_store(ref_mem[idx], wd, a[1:0], f3);
            lat = (f3 == 3'b010) ? 8'd2 : 8'd4;
        end else begin
            data = ref_load(ref_mem[idx], a[1:0], f3);
            we   = 1'b1;
            lat  = 8'd3;
        end
        exp_q.push_back({lat, rd, we, exc, data});

        @(negedge clk);
        bus.req_valid_i    = 1'b1;
        bus.req_is_store_i = st;
        bus.req_funct3_i   = f3;
        bus.req_addr_i     = a;
        bus.req_wdata_i    = wd;
        bus.req_rd_i       = rd;
        w = 0;
        while (!bus.req_ready_o && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (w >= 20) check("accept_timeout", 64'(w), 64'd0);
        @(posedge clk);
        #1;
        acc_q.push_back(cyc);
        check("ready_low_after_accept", 64'(bus.req_ready_o), 64'd0);
        if (!hold) bus.req_valid_i = 1'b0;
    endtask

    task automatic wait_done();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (rst_n && bus.resp_valid_o) begin
            if (exp_q.size() == 0 || acc_q.size() == 0) begin
                check("unexpected_resp", 64'd1, 64'd0);
            end else begin
                logic [W-1:0] e;
                int           a;
                e = exp_q.pop_front();
                a = acc_q.pop_front();
                check("resp_data",   64'(bus.resp_data_o), 64'(e[31:0]));
                check("resp_exc",    64'(bus.resp_exc_o),  64'(e[33:32]));
                check("resp_we",     64'(bus.resp_we_o),   64'(e[34]));
                check("resp_rd",     64'(bus.resp_rd_o),   64'(e[39:35]));
                check("resp_lat",    64'(cyc - a + 1),     64'(e[47:40]));
                check("ready_in_resp", 64'(bus.req_ready_o), 64'd0);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int we0, re0;
        rst_n              = 1'b0;
        bus.req_valid_i    = 1'b0;
        bus.req_is_store_i = 1'b0;
        bus.req_funct3_i   = 3'b000;
        bus.req_addr_i     = 32'h0;
        bus.req_wdata_i    = 32'h0;
        bus.req_rd_i       = 5'd0;
        for (int i = 0; i < 256; i++) ref_mem[i] = $urandom;
        ref_mem[5] = 32'h8899_AABB;
        for (int i = 0; i < 256; i++) mem[i] <= ref_mem[i];
        bus.mem_rdata_i <= 32'h0;

        repeat (3) @(negedge clk);
        check("rst_ready",      64'(bus.req_ready_o),  64'd1);
        check("rst_resp_valid", 64'(bus.resp_valid_o), 64'd0);
        check("rst_mem_we",     64'(bus.mem_we_o),     64'd0);
        check("rst_mem_re",     64'(bus.mem_re_o),     64'd0);
        check("rst_resp_data",  64'(bus.resp_data_o),  64'd0);
        check("rst_mem_addr",   64'(bus.mem_addr_o),   64'd0);
        check("rst_state",      64'(dbg_state),        64'd0);
        rst_n = 1'b1;

        // Loads from mem[5]
        issue(1'b0, 3'b000, 32'h16, 32'h0, 5'd3, 1'b0);  wait_done();
        issue(1'b0, 3'b101, 32'h16, 32'h0, 5'd4, 1'b0);  wait_done();
        issue(1'b0, 3'b001, 32'h14, 32'h0, 5'd5, 1'b0);  wait_done();

        // SB into byte 1 of mem[5]
        we0 = we_cnt;
        issue(1'b1, 3'b000, 32'h15, 32'h0000_00CC, 5'd6, 1'b0);  wait_done();
        check("sb_we_pulses", 64'(we_cnt - we0), 64'd1);
        check("sb_mem5",      64'(mem[5]),       64'h8899_CCBB);

        // Exceptions make no memory access
        we0 = we_cnt;
        re0 = re_cnt;
        issue(1'b0, 3'b010, 32'h22, 32'h0, 5'd7, 1'b0);       wait_done();
        issue(1'b0, 3'b011, 32'h20, 32'h0, 5'd8, 1'b0);       wait_done();
        issue(1'b1, 3'b011, 32'h23, 32'h1234, 5'd9, 1'b0);    wait_done();
        issue(1'b1, 3'b001, 32'h15, 32'h1234, 5'd10, 1'b0);   wait_done();
        issue(1'b0, 3'b101, 32'h17, 32'h0, 5'd11, 1'b0);      wait_done();
        check("exc_no_we", 64'(we_cnt - we0), 64'd0);
        check("exc_no_re", 64'(re_cnt - re0), 64'd0);

        // SH abandoned by reset during RDW
        @(negedge clk);
        bus.req_valid_i    = 1'b1;
        bus.req_is_store_i = 1'b1;
        bus.req_funct3_i   = 3'b001;
        bus.req_addr_i     = 32'h32;
        bus.req_wdata_i    = 32'h0000_5A5A;
        bus.req_rd_i       = 5'd12;
        @(posedge clk);
        #1 bus.req_valid_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("pre_rst_in_rdw", 64'(dbg_state), 64'd2);
        rst_n = 1'b0;
        #1;
        check("midrst_ready",      64'(bus.req_ready_o),  64'd1);
        check("midrst_resp_valid", 64'(bus.resp_valid_o), 64'd0);
        check("midrst_mem_we",     64'(bus.mem_we_o),     64'd0);
        check("midrst_mem_re",     64'(bus.mem_re_o),     64'd0);
        check("midrst_wdata",      64'(bus.mem_wdata_o),  64'd0);
        check("midrst_resp_rd",    64'(bus.resp_rd_o),    64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("midrst_mem12", 64'(mem[12]), 64'(ref_mem[12]));
        issue(1'b0, 3'b010, 32'h30, 32'h0, 5'd13, 1'b0);  wait_done();

        // Back-to-back with req_valid_i held high
        issue(1'b1, 3'b010, 32'h40, 32'hDEAD_BEEF, 5'd1, 1'b1);
        issue(1'b1, 3'b000, 32'h43, 32'h0000_0011, 5'd2, 1'b1);
        issue(1'b0, 3'b010, 32'h40, 32'h0, 5'd14, 1'b1);
        issue(1'b1, 3'b001, 32'h42, 32'h0000_7766, 5'd15, 1'b1);
        issue(1'b0, 3'b000, 32'h41, 32'h0, 5'd16, 1'b1);
        issue(1'b0, 3'b111, 32'h40, 32'h0, 5'd17, 1'b1);
        issue(1'b0, 3'b101, 32'h42, 32'h0, 5'd18, 1'b0);
        wait_done();

        // Randomised traffic
        for (int i = 0; i < 60; i++) begin
            logic [31:0] a;
            a = 32'($urandom_range(0, 1023));
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a,
                  $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
        end
        wait_done();

        // Address beyond the memory
        we0 = we_cnt;
        re0 = re_cnt;
        issue(1'b0, 3'b010, 32'h400, 32'h0, 5'd19, 1'b0);  wait_done();
`ifdef LSU_ACCESS_FAULT_EN
        check("fault_no_re", 64'(re_cnt - re0), 64'd0);
`else
        check("wrap_one_re", 64'(re_cnt - re0), 64'd1);
`endif
        check("far_no_we", 64'(we_cnt - we0), 64'd0);

        for (int i = 0; i < 256; i++) begin
            if (mem[i] !== ref_mem[i]) check("final_mem", 64'(mem[i]), 64'(ref_mem[i]));
        end
        check("final_mem_words_0", 64'(mem[0]), 64'(ref_mem[0]));
        check("final_exp_q", 64'(exp_q.size()), 64'd0);
        check("final_acc_q", 64'(acc_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global time limit.
    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
